// File: rtl/mem_port_responder.sv
// Responder end of the multicycle CPU memory port: word RAM, configurable wait states,
// one-cycle Ready/AddrErr completion. Define MEM_BYTE_EN_EN for per-lane write enables.
module mem_port_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              WrEn,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] WData,
`ifdef MEM_BYTE_EN_EN
    input  logic [3:0]        ByteEn,
`endif
    output logic [DATA_W-1:0] RData,
    output logic              Ready,
    output logic              Busy,
    output logic              AddrErr
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wr_q;
    logic                misal_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wmask;
    logic                commit;
    logic                accept;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_BYTE_EN_EN
    logic [3:0]          be_q;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_W+2];

    // A request is captured into pend_q first; the FSM leaves IDLE one edge later.
    assign accept = (state_q == ST_IDLE) && !pend_q && Req;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            misal_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef MEM_BYTE_EN_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                wr_q    <= WrEn;
                misal_q <= |Address[1:0];
                idx_q   <= Address[ADDR_W+1:2];
                wdata_q <= WData;
`ifdef MEM_BYTE_EN_EN
                be_q    <= ByteEn;
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (misal_q) begin
                        state_d = ST_ERR;
                    end else if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (Req) begin
                    pend_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (commit && !wr_q) begin
            rdata_d = mem[idx_q];
        end
    end

    always_comb begin
        wmask = '1;
`ifdef MEM_BYTE_EN_EN
        wmask = DATA_W'({{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}});
`endif
    end

    // RAM is deliberately not reset; writes land only on the RESP-entry edge.
    always_ff @(posedge Clk) begin
        if (commit && wr_q) begin
            mem[idx_q] <= (mem[idx_q] & ~wmask) | (wdata_q & wmask);
        end
    end

    assign RData   = rdata_q;
    assign Ready   = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign AddrErr = (state_q == ST_ERR);
    assign Busy    = (state_q != ST_IDLE);

endmodule
